// File: rtl/pc_pkg.sv
// Shared types for the program-counter block: command encoding and the
// per-cycle priority decode (ret > call > load > enable > hold).
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET,
    PC_ILLEGAL
  } pc_op_e;

  // A blocked ret or call swallows every lower-priority strobe in the same cycle.
  function automatic pc_op_e pc_decode(input logic ret, input logic call,
                                       input logic load, input logic enable,
                                       input logic full, input logic empty);
    pc_op_e op;
    if (ret)         op = empty ? PC_ILLEGAL : PC_RET;
    else if (call)   op = full ? PC_ILLEGAL : PC_CALL;
    else if (load)   op = PC_LOAD;
    else if (enable) op = PC_INC;
    else             op = PC_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_counter_return_stack.sv
// Return-address LIFO: storage array plus depth register. The caller
// guarantees push only when not full and pop only when not empty.
module return_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     depth_q <= '0;
    else if (push) depth_q <= depth_q + DW'(1);
    else if (pop)  depth_q <= depth_q - DW'(1);
  end

  // Storage is deliberately left out of reset; entries above depth are don't-care.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (push && depth_q == DW'(i)) mem[i] <= push_data;
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (depth_q == DW'(i + 1)) top = mem[i];
  end

  assign depth = depth_q;

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with load/increment and call/return via an internal stack.
// Optional PC_STACK_ERR_EN adds a sticky err flag that halts the counter.
module pc_stack_counter
  import pc_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       load,
  input  logic [WIDTH-1:0]           valueLoad,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
`ifdef PC_STACK_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int DW = $clog2(DEPTH + 1);

  pc_op_e           op;
  logic             halt;
  logic             push, pop;
  logic [WIDTH-1:0] top;

  assign full  = (depth == DW'(DEPTH));
  assign empty = (depth == '0);
  assign op    = pc_decode(ret, call, load, enable, full, empty);

`ifdef PC_STACK_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 err <= 1'b0;
    else if (op == PC_ILLEGAL) err <= 1'b1;
  end
  assign halt = err;
`else
  assign halt = 1'b0;
`endif

  assign push = !halt && (op == PC_CALL);
  assign pop  = !halt && (op == PC_RET);

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DW(DW)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (out + WIDTH'(1)),
    .top       (top),
    .depth     (depth)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= '0;
    else if (!halt) begin
      case (op)
        PC_INC:           out <= out + WIDTH'(1);
        PC_LOAD, PC_CALL: out <= valueLoad;
        PC_RET:           out <= top;
        default:          out <= out;
      endcase
    end
  end

endmodule
